// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit: EXU-facing request/response handshake driving a single-port SRAM.
// One request in flight; load data is aligned and extended, and store data is replicated across byte lanes.
module ysyx_24110015_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask
);

  localparam int unsigned LANES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DATA, WR, RESP} state_t;

  state_t          state;
  logic [1:0]      off_q;
  logic [1:0]      size_q;
  logic            uns_q;

  logic                  req_err_c;
  logic [ADDR_WIDTH-1:0] word_addr_c;
  logic [DATA_WIDTH-1:0] st_data_c;
  logic [LANES-1:0]      st_mask_c;
  logic [DATA_WIDTH-1:0] ld_shift_c;
  logic [DATA_WIDTH-1:0] ld_data_c;

  assign req_ready   = (state == IDLE);
  assign word_addr_c = {req_addr[ADDR_WIDTH-1:2], 2'b00};

  // Size legality and natural alignment of the incoming request
  always_comb begin
    req_err_c = 1'b0;
    case (req_size)
      2'd0:    req_err_c = 1'b0;
      2'd1:    req_err_c = req_addr[0];
      2'd2:    req_err_c = |req_addr[1:0];
      default: req_err_c = 1'b1;
    endcase
  end

  // Store data replicated into every lane the mask may select
  always_comb begin
    st_data_c = req_wdata;
    st_mask_c = 4'hF;
    case (req_size)
      2'd0: begin
        st_data_c = {4{req_wdata[7:0]}};
        st_mask_c = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        st_data_c = {2{req_wdata[15:0]}};
        st_mask_c = 4'b0011 << req_addr[1:0];
      end
      default: begin
        st_data_c = req_wdata;
        st_mask_c = 4'hF;
      end
    endcase
  end

  // Load alignment and sign/zero extension of the returned SRAM word
  always_comb begin
    ld_shift_c = mem_rdata >> {off_q, 3'b000};
    ld_data_c  = ld_shift_c;
    case (size_q)
      2'd0:    ld_data_c = {{24{ld_shift_c[7] & ~uns_q}}, ld_shift_c[7:0]};
      2'd1:    ld_data_c = {{16{ld_shift_c[15] & ~uns_q}}, ld_shift_c[15:0]};
      default: ld_data_c = ld_shift_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_ren    <= 1'b0;
      mem_raddr  <= '0;
      mem_wen    <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= 4'h0;
    end else begin
      // Memory enables are single-cycle pulses
      mem_ren <= 1'b0;
      mem_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q  <= req_addr[1:0];
            size_q <= req_size;
            uns_q  <= req_unsigned;
            if (req_err_c) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (req_wen) begin
              mem_wen   <= 1'b1;
              mem_waddr <= word_addr_c;
              mem_wdata <= st_data_c;
              mem_wmask <= st_mask_c;
              state     <= WR;
            end else begin
              mem_ren   <= 1'b1;
              mem_raddr <= word_addr_c;
              state     <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: state <= RD_DATA;
        RD_DATA: begin
          resp_rdata <= ld_data_c;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Directed bench for the LSU: vector table of loads and stores against a small SRAM model,
// plus backpressure and reset-during-write sequences.
module tb_ysyx_24110015_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic [3:0]  mem_wmask;

  int n_assert = 0;
  int n_fail   = 0;

  ysyx_24110015_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask)
  );

  always #5 clk = ~clk;

  // Four-word SRAM model; read data appears one cycle after mem_ren, junk otherwise
  logic [31:0] mem [4];
  always @(posedge clk) begin
    if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_waddr[3:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= mem_ren ? mem[mem_raddr[3:2]] : 32'h5A5A5A5A;
  end

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mwdata;
    logic [3:0]  mmask;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a request, check the memory pulse and the response latency
  task automatic start(input string tag, input vec_t v);
    int lat, ren_n, wen_n, exp_lat;
    @(negedge clk);
    req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; ren_n = 0; wen_n = 0;
    for (int c = 1; c <= 6; c++) begin
      if (mem_ren) begin
        ren_n++;
        chk({tag, "_ren_cycle"}, 32'(c), 32'd1);
        chk({tag, "_raddr"}, mem_raddr, {v.addr[31:2], 2'b00});
      end
      if (mem_wen) begin
        wen_n++;
        chk({tag, "_wen_cycle"}, 32'(c), 32'd1);
        chk({tag, "_waddr"}, mem_waddr, {v.addr[31:2], 2'b00});
        chk({tag, "_wdata"}, mem_wdata, v.mwdata);
        chk({tag, "_wmask"}, 32'(mem_wmask), 32'(v.mmask));
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    exp_lat = v.err ? 1 : (v.wen ? 2 : 3);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_ren_count"}, 32'(ren_n), (!v.err && !v.wen) ? 32'd1 : 32'd0);
    chk({tag, "_wen_count"}, 32'(wen_n), (!v.err && v.wen) ? 32'd1 : 32'd0);
    chk({tag, "_rdata"}, resp_rdata, v.rdata);
    chk({tag, "_err"}, 32'(resp_err), 32'(v.err));
  endtask

  task automatic complete(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_valid_clr"}, 32'(resp_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    logic [31:0] held;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    //           wen   addr          wdata          sz    uns   err   rdata          mwdata         mmask
    vecs[0]  = '{1'b1, 32'h80000000, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 32'h00000000, 32'hDEADBEEF, 4'hF};
    vecs[1]  = '{1'b0, 32'h80000000, 32'h0,        2'd2, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        4'h0};
    vecs[2]  = '{1'b1, 32'h80000003, 32'h000000A5, 2'd0, 1'b0, 1'b0, 32'h00000000, 32'hA5A5A5A5, 4'h8};
    vecs[3]  = '{1'b0, 32'h80000003, 32'h0,        2'd0, 1'b0, 1'b0, 32'hFFFFFFA5, 32'h0,        4'h0};
    vecs[4]  = '{1'b0, 32'h80000003, 32'h0,        2'd0, 1'b1, 1'b0, 32'h000000A5, 32'h0,        4'h0};
    vecs[5]  = '{1'b1, 32'h80000000, 32'h80011234, 2'd2, 1'b0, 1'b0, 32'h00000000, 32'h80011234, 4'hF};
    vecs[6]  = '{1'b0, 32'h80000002, 32'h0,        2'd1, 1'b1, 1'b0, 32'h00008001, 32'h0,        4'h0};
    vecs[7]  = '{1'b0, 32'h80000002, 32'h0,        2'd1, 1'b0, 1'b0, 32'hFFFF8001, 32'h0,        4'h0};
    vecs[8]  = '{1'b0, 32'h80000000, 32'h0,        2'd1, 1'b0, 1'b0, 32'h00001234, 32'h0,        4'h0};
    vecs[9]  = '{1'b0, 32'h80000001, 32'h0,        2'd0, 1'b0, 1'b0, 32'h00000012, 32'h0,        4'h0};
    vecs[10] = '{1'b0, 32'h80000002, 32'h0,        2'd2, 1'b0, 1'b1, 32'h00000000, 32'h0,        4'h0};
    vecs[11] = '{1'b0, 32'h80000000, 32'h0,        2'd3, 1'b0, 1'b1, 32'h00000000, 32'h0,        4'h0};
    vecs[12] = '{1'b1, 32'h80000001, 32'h0000BEEF, 2'd1, 1'b0, 1'b1, 32'h00000000, 32'h0,        4'h0};
    vecs[13] = '{1'b1, 32'h80000006, 32'h0000BEEF, 2'd1, 1'b0, 1'b0, 32'h00000000, 32'hBEEFBEEF, 4'hC};
    vecs[14] = '{1'b0, 32'h80000004, 32'h0,        2'd2, 1'b0, 1'b0, 32'hBEEF0000, 32'h0,        4'h0};
    vecs[15] = '{1'b0, 32'h80000006, 32'h0,        2'd1, 1'b1, 1'b0, 32'h0000BEEF, 32'h0,        4'h0};
    vecs[16] = '{1'b1, 32'h80000005, 32'h1234567F, 2'd0, 1'b0, 1'b0, 32'h00000000, 32'h7F7F7F7F, 4'h2};
    vecs[17] = '{1'b0, 32'h80000005, 32'h0,        2'd0, 1'b0, 1'b0, 32'h0000007F, 32'h0,        4'h0};

    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_en", {30'd0, mem_ren, mem_wen}, 32'd0);
    chk("rst_addrs", mem_raddr | mem_waddr | mem_wdata, 32'd0);
    chk("rst_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      start($sformatf("v%0d", i), vecs[i]);
      complete($sformatf("v%0d", i));
    end

    // Backpressure: response held while a competing store request is presented
    v = vecs[1];
    v.rdata = 32'h80011234;
    start("bp", v);
    held = resp_rdata;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h80000000; req_wdata = 32'h0;
      req_size = 2'd2;
      chk($sformatf("bp_valid%0d", k), 32'(resp_valid), 32'd1);
      chk($sformatf("bp_rdata%0d", k), resp_rdata, held);
      chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp_wen%0d", k), 32'(mem_wen), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_valid_clr", 32'(resp_valid), 32'd0);
    chk("bp_ready_back", 32'(req_ready), 32'd1);
    chk("bp_no_accept", 32'(mem_wen), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_idle_quiet", {30'd0, mem_wen, resp_valid}, 32'd0);

    // Reset asserted while the write pulse is on the SRAM port
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h80000008; req_wdata = 32'h11111111;
    req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_wen_up", 32'(mem_wen), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_wen_drop", 32'(mem_wen), 32'd0);
    chk("rw_outs", mem_waddr | mem_wdata | resp_rdata, 32'd0);
    chk("rw_flags", {27'd0, mem_wmask, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw_no_resp", 32'(resp_valid), 32'd0);
    chk("rw_ready", 32'(req_ready), 32'd1);
    v = vecs[1];
    v.addr = 32'h80000008;
    v.rdata = 32'h0;
    start("rw_readback", v);
    complete("rw_readback");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_lsu.md
Name: ysyx_24110015_lsu

Overview:
- Load/store unit: the initiator side of the single-port SRAM memory interface.
- Accepts one load or store request from EXU over a valid/ready handshake.
- Drives the SRAM read port (ren/raddr, rdata registered 1 cycle after ren) and the write port (wen/waddr/wdata/wmask).
- Aligns and extends load data; returns one response per request.
- Sits between EXU and the data SRAM; one outstanding request at a time.

Parameters:
ADDR_WIDTH, 32, request/memory address width
DATA_WIDTH, 32, data width; the design supports only 32 (4 byte lanes)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  LSU can accept a request (combinational: state==IDLE)
req_wen  input  1  1=store, 0=load
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data, right-aligned
req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  input  1  load zero-extend (1) / sign-extend (0)
resp_valid  output  1  response valid
resp_ready  input  1  consumer accepts response
resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal-size request
mem_ren  output  1  SRAM read enable
mem_raddr  output  ADDR_WIDTH  word-aligned read address (addr & ~3)
mem_rdata  input  DATA_WIDTH  SRAM read data, valid the cycle after mem_ren
mem_wen  output  1  SRAM write enable
mem_waddr  output  ADDR_WIDTH  word-aligned write address
mem_wdata  output  DATA_WIDTH  lane-replicated store data
mem_wmask  output  4  byte-lane write mask, bit i = byte i

Behaviour:
- Reset values (rst_n low, asynchronous):
  - state=IDLE.
  - resp_valid, resp_err, mem_ren, mem_wen = 0.
  - resp_rdata, mem_raddr, mem_waddr, mem_wdata = 0; mem_wmask = 0.
- FSM states: IDLE, RD_ISSUE, RD_DATA, WR, RESP. All mem_* and resp_* outputs are registered.
- IDLE: request accepted when req_valid && req_ready. On accept, latch wen, addr[1:0], size, unsigned.
  - Alignment check: half needs addr[0]=0; word needs addr[1:0]=0; size 3 is always illegal.
  - Any alignment or size error -> RESP with resp_err=1, resp_rdata=0. No memory access.
  - Legal load -> RD_ISSUE with mem_ren=1 and mem_raddr=addr&~3.
  - Legal store -> WR with mem_wen=1, mem_waddr=addr&~3, plus mask and data as below.
- RD_ISSUE: mem_ren high for exactly this cycle -> RD_DATA.
- RD_DATA: mem_rdata is valid this cycle.
  - Shift right by 8*addr[1:0], keep 8/16/32 bits per size.
  - Extend: sign if !unsigned, else zero.
  - Register into resp_rdata; resp_valid=1 next cycle -> RESP.
- WR: mem_wen high for exactly this cycle -> RESP (resp_err=0, resp_rdata=0).
- Store lane rules:
  - byte: wdata={4{wdata[7:0]}}, wmask=4'b0001<<addr[1:0].
  - half: wdata={2{wdata[15:0]}}, wmask=4'b0011<<addr[1:0].
  - word: wdata unchanged, wmask=4'hF.
- RESP: resp_valid held high; resp_rdata and resp_err held stable until resp_ready.
  - On resp_valid && resp_ready: clear resp_valid, go to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- Latency, accept at cycle T:
  - Load: mem_ren at T+1, data captured T+2, resp_valid at T+3.
  - Store: mem_wen at T+1, resp_valid at T+2.
  - Error: resp_valid at T+1.
- mem_ren and mem_wen are never both high. Each is a single-cycle pulse per request.
- req_* inputs are ignored outside IDLE.
- Reset mid-operation: the current request is abandoned. mem_wen/mem_ren drop immediately (asynchronous), so no partial write commits after reset asserts. No response is produced.

Test Plan:
- Store word 0xDEADBEEF @0x80000000, then load word same addr (unsigned=0) -> mem_wen at T+1 with wmask=F; load resp_valid at T+3, resp_rdata=0xDEADBEEF, resp_err=0.
- Store byte 0x000000A5 @0x80000003 -> mem_waddr=0x80000000, mem_wdata=0xA5A5A5A5, mem_wmask=4'b1000. Then lb signed same addr with mem_rdata=0xA5xxxxxx -> resp_rdata=0xFFFFFFA5.
- lhu @0x80000002 with mem_rdata=0x8001_1234 -> resp_rdata=0x00008001; lh -> 0xFFFF8001.
- Misaligned word load @0x80000002, and size=3 @0x80000000 -> resp_valid at T+1, resp_err=1, resp_rdata=0, mem_ren/mem_wen never asserted.
- Backpressure: resp_ready held low 5 cycles after resp_valid -> resp_valid and resp_rdata stable, req_ready=0, a new req_valid is not accepted; resp_ready=1 -> IDLE next cycle, req_ready=1.
- Pull rst_n low during the WR cycle -> mem_wen falls immediately, all outputs at reset values, no resp_valid. After release, req_ready=1.
